disparity_row_scheduler: RTL and testbench

DISPARITY_ROW_SCHEDULER -- requirements
Module: disparity_row_scheduler

---
 rtl/disparity_row_scheduler.sv | 168 ++++++++++++++++
 tb/tb_disparity_row_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_row_scheduler.sv
// disparity_row_scheduler: steps a loaded WIN-row band through a per-pixel disparity core, one column at a time.
// Latency: 3 cycles plus core latency per column (CORE_RST, START, WAIT..., EMIT); an empty row takes 2 cycles.
// Backpressure: EMIT holds the result beat until disp_ready; no new row is accepted until the current row completes.
module disparity_row_scheduler #(
  parameter int IMG_W     = 64,
  parameter int DISP_BITS = 6,
  parameter int COL_BITS  = 6,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [COL_BITS:0]    cfg_num_cols,
  output logic                 core_rst,
  output logic                 core_start,
  output logic [COL_BITS-1:0]  core_col,
  input  logic                 core_done,
  input  logic [DISP_BITS-1:0] core_disp,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [DISP_BITS-1:0] disp_data,
  output logic [COL_BITS-1:0]  disp_col,
  output logic                 disp_last,
  output logic                 disp_timeout,
  output logic                 row_done,
  output logic [7:0]           err_count
);

  // The timer only has to reach TIMEOUT-1; one spare bit keeps the compare simple for any TIMEOUT.
  localparam int TMR_BITS = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);
  localparam logic [TMR_BITS-1:0] TMR_ONE  = TMR_BITS'(1);
  localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
  localparam logic [COL_BITS:0]   N_ONE    = (COL_BITS + 1)'(1);
  localparam logic [COL_BITS:0]   IMG_W_N  = (COL_BITS + 1)'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_START,
    S_WAIT,
    S_EMIT,
    S_ROW_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [COL_BITS-1:0]    col;
  logic [COL_BITS:0]      num_cols;
  logic [COL_BITS:0]      cfg_clamped;
  logic [TMR_BITS-1:0]    timer;
  logic [DISP_BITS-1:0]   disp_data_q;
  logic                   disp_timeout_q;
  logic [7:0]             err_q;
  // Keeps row_ready low while reset is held even though the FSM already sits in IDLE.
  logic                   armed;
  logic                   accept;
  logic                   col_last;
  logic                   tmo_hit;

  // Row acceptance, last-column and timeout decode shared by the FSM and the datapath.
  always_comb begin
    accept      = (state == S_IDLE) && armed && row_valid;
    col_last    = ({1'b0, col} == (num_cols - N_ONE));
    tmo_hit     = (timer == TMR_LAST);
    cfg_clamped = (cfg_num_cols > IMG_W_N) ? IMG_W_N : cfg_num_cols;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a done from the core wins over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (cfg_num_cols == '0) ? S_ROW_DONE : S_CORE_RST;
        end
      end
      S_CORE_RST: state_nxt = S_START;
      S_START:    state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done || tmo_hit) begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (disp_ready) begin
          state_nxt = col_last ? S_ROW_DONE : S_CORE_RST;
        end
      end
      S_ROW_DONE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; core_rst also follows rst directly so a mid-row reset re-arms the core.
  always_comb begin
    row_ready    = (state == S_IDLE) && armed;
    core_rst     = rst || (state == S_CORE_RST);
    core_start   = (state == S_START) || (state == S_WAIT);
    core_col     = col;
    disp_valid   = (state == S_EMIT);
    disp_data    = disp_data_q;
    disp_col     = col;
    disp_last    = (state == S_EMIT) && col_last;
    disp_timeout = disp_timeout_q;
    row_done     = (state == S_ROW_DONE);
    err_count    = err_q;
  end

  // Row bookkeeping: latch the clamped column count on accept and advance col on each non-final handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      num_cols <= '0;
      col      <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        num_cols <= cfg_clamped;
        col      <= '0;
      end else if ((state == S_EMIT) && disp_ready && !col_last) begin
        col <= col + COL_ONE;
      end
    end
  end

  // Per-column watchdog: cleared in START, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == S_START) begin
      timer <= '0;
    end else if (state == S_WAIT) begin
      timer <= timer + TMR_ONE;
    end
  end

  // Result capture: core value on done, forced zero plus timeout flag and error count otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data_q    <= '0;
      disp_timeout_q <= 1'b0;
      err_q          <= '0;
    end else if (state == S_WAIT) begin
      if (core_done) begin
        disp_data_q    <= core_disp;
        disp_timeout_q <= 1'b0;
      end else if (tmo_hit) begin
        disp_data_q    <= '0;
        disp_timeout_q <= 1'b1;
        if (err_q != 8'hFF) begin
          err_q <= err_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_disparity_row_scheduler.sv
// Bench for disparity_row_scheduler: table rows, hand-built corner sequences and random rows.
// A behavioural core model answers each column after a chosen latency (0 = never answers).
// Expected beats, timeouts and cycle counts come from per-column latency rules, not from the FSM.
module tb_disparity_row_scheduler;
  localparam int IMG_W     = 64;
  localparam int DISP_BITS = 6;
  localparam int COL_BITS  = 6;
  localparam int TIMEOUT   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 row_valid;
  logic                 row_ready;
  logic [COL_BITS:0]    cfg_num_cols;
  logic                 core_rst;
  logic                 core_start;
  logic [COL_BITS-1:0]  core_col;
  logic                 core_done = 1'b0;
  logic [DISP_BITS-1:0] core_disp = '0;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [DISP_BITS-1:0] disp_data;
  logic [COL_BITS-1:0]  disp_col;
  logic                 disp_last;
  logic                 disp_timeout;
  logic                 row_done;
  logic [7:0]           err_count;

  disparity_row_scheduler #(
    .IMG_W(IMG_W), .DISP_BITS(DISP_BITS), .COL_BITS(COL_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready),
    .cfg_num_cols(cfg_num_cols), .core_rst(core_rst), .core_start(core_start),
    .core_col(core_col), .core_done(core_done), .core_disp(core_disp),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
    .disp_col(disp_col), .disp_last(disp_last), .disp_timeout(disp_timeout),
    .row_done(row_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int err_model = 0;
  int core_cnt = 0;
  int lat_tab [IMG_W];
  logic [DISP_BITS-1:0] disp_tab [IMG_W];

  typedef struct {
    int cfg;
    int lat;
    int ready_pct;
    int exp_beats;
    int exp_err_inc;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Core model: counts core_start cycles since its last reset and raises done at the column's latency.
  always @(negedge clk) begin
    if (core_rst) begin
      core_cnt  = 0;
      core_done = 1'b0;
    end else if (core_start && !core_done) begin
      core_cnt = core_cnt + 1;
      if (lat_tab[core_col] != 0 && core_cnt == lat_tab[core_col]) begin
        core_done = 1'b1;
        core_disp = disp_tab[core_col];
      end
    end
  end

  function automatic bit col_times_out(input int lat);
    return (lat == 0) || (lat > TIMEOUT + 1);
  endfunction

  // Runs one row from accept to row_done, checking every beat and the per-row totals.
  task automatic run_row(input int cfg, input int ready_pct, input int stall_first, output int beats);
    int n_eff, idx, cyc, budget, rd_seen, rd_cyc, rst_pulses, start_cyc, exp_start, tos, stall;
    bit prev_hold, to;
    logic [DISP_BITS-1:0] pd;
    logic [COL_BITS-1:0]  pc;
    logic pl, pt;
    n_eff = (cfg > IMG_W) ? IMG_W : cfg;
    exp_start = 0;
    tos = 0;
    for (int c = 0; c < n_eff; c++) begin
      if (col_times_out(lat_tab[c])) begin
        exp_start += 1 + TIMEOUT;
        tos++;
      end else begin
        exp_start += 1 + ((lat_tab[c] < 2) ? 1 : lat_tab[c] - 1);
      end
    end
    cyc = 0;
    while (!row_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("row_ready_before_row", row_ready, 1);
    cfg_num_cols = (COL_BITS + 1)'(cfg);
    row_valid = 1'b1;
    budget = 100 + stall_first + n_eff * (TIMEOUT + 60);
    idx = 0; rd_seen = 0; rd_cyc = 0; rst_pulses = 0; start_cyc = 0; stall = 0;
    prev_hold = 1'b0; pd = '0; pc = '0; pl = 1'b0; pt = 1'b0;
    for (cyc = 1; cyc <= budget && rd_seen == 0; cyc++) begin
      @(negedge clk);
      row_valid = 1'b0;
      cfg_num_cols = (COL_BITS + 1)'($urandom);
      if (prev_hold) begin
        chk("hold_valid", disp_valid, 1);
        chk("hold_data", disp_data, pd);
        chk("hold_col", disp_col, pc);
        chk("hold_last", disp_last, pl);
        chk("hold_timeout", disp_timeout, pt);
      end
      if (disp_valid) begin
        chk("emit_core_start", core_start, 0);
        chk("emit_core_rst", core_rst, 0);
      end
      if (core_rst || core_start) chk("core_col", core_col, idx);
      chk("busy_row_ready", row_ready, 0);
      if (core_rst) rst_pulses++;
      if (core_start) start_cyc++;
      if (row_done) begin
        rd_seen = 1;
        rd_cyc = cyc;
      end
      if (disp_valid && stall < stall_first) begin
        disp_ready = 1'b0;
        stall++;
      end else begin
        disp_ready = ($urandom_range(99) < ready_pct);
      end
      prev_hold = disp_valid && !disp_ready;
      pd = disp_data; pc = disp_col; pl = disp_last; pt = disp_timeout;
      if (disp_valid && disp_ready) begin
        if (idx < n_eff) begin
          to = col_times_out(lat_tab[idx]);
          chk("beat_col", disp_col, idx);
          chk("beat_data", disp_data, to ? 0 : disp_tab[idx]);
          chk("beat_timeout", disp_timeout, to);
          chk("beat_last", disp_last, idx == n_eff - 1);
        end
        idx++;
      end
    end
    chk("row_done_seen", rd_seen, 1);
    chk("beat_count", idx, n_eff);
    chk("core_rst_pulses", rst_pulses, n_eff);
    chk("core_start_cycles", start_cyc, exp_start);
    if (n_eff == 0) chk("empty_row_latency_ok", (rd_cyc >= 1 && rd_cyc <= 2), 1);
    @(negedge clk);
    chk("row_done_one_cycle", row_done, 0);
    chk("idle_row_ready", row_ready, 1);
    err_model = (err_model + tos > 255) ? 255 : err_model + tos;
    chk("err_count", err_count, err_model);
    beats = idx;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int beats, eb, found;
    tbl[0] = '{4,   21, 100, 4,  0};
    tbl[1] = '{0,   5,  100, 0,  0};
    tbl[2] = '{1,   0,  100, 1,  1};
    tbl[3] = '{3,   33, 80,  3,  0};
    tbl[4] = '{2,   34, 60,  2,  2};
    tbl[5] = '{100, 2,  70,  64, 0};
    tbl[6] = '{64,  1,  100, 64, 0};
    tbl[7] = '{65,  3,  50,  64, 0};
    for (int c = 0; c < IMG_W; c++) begin
      lat_tab[c] = 5;
      disp_tab[c] = DISP_BITS'(c + 10);
    end
    rst = 1'b1; row_valid = 1'b0; disp_ready = 1'b0; cfg_num_cols = '0;

    // Reset values, held across a clock edge.
    @(negedge clk);
    @(negedge clk);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_disp_col", disp_col, 0);
    chk("rst_disp_last", disp_last, 0);
    chk("rst_disp_timeout", disp_timeout, 0);
    rst = 1'b0;
    #1;
    chk("release_before_edge_row_ready", row_ready, 0);
    chk("release_core_rst", core_rst, 0);
    @(negedge clk);
    chk("release_first_edge_row_ready", row_ready, 1);

    // Table-driven rows: uniform core latency per row.
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < IMG_W; c++) begin
        lat_tab[c] = tbl[i].lat;
        disp_tab[c] = DISP_BITS'(c + 10);
      end
      eb = err_model;
      run_row(tbl[i].cfg, tbl[i].ready_pct, 0, beats);
      chk("tbl_beats", beats, tbl[i].exp_beats);
      chk("tbl_err_count", err_count, eb + tbl[i].exp_err_inc);
    end

    // Consumer stalls 15 cycles on the first beat of a two-column row.
    for (int c = 0; c < IMG_W; c++) lat_tab[c] = 5;
    run_row(2, 100, 15, beats);
    chk("stall_row_beats", beats, 2);

    // Reset while column 5 is waiting on the core.
    for (int c = 0; c < IMG_W; c++) begin
      lat_tab[c] = 8;
      disp_tab[c] = DISP_BITS'($urandom);
    end
    cfg_num_cols = (COL_BITS + 1)'(10);
    row_valid = 1'b1;
    disp_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      @(negedge clk);
      row_valid = 1'b0;
      if (core_start && core_col == 5) found = 1;
    end
    chk("reached_col5", found, 1);
    @(negedge clk);
    @(negedge clk);
    chk("col5_waiting", core_start, 1);
    rst = 1'b1;
    #1;
    chk("midrow_core_rst", core_rst, 1);
    chk("midrow_core_start", core_start, 0);
    chk("midrow_row_ready", row_ready, 0);
    chk("midrow_disp_valid", disp_valid, 0);
    chk("midrow_core_col", core_col, 0);
    chk("midrow_err_count", err_count, 0);
    chk("midrow_disp_timeout", disp_timeout, 0);
    chk("midrow_disp_data", disp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    err_model = 0;
    @(negedge clk);
    chk("midrow_release_row_ready", row_ready, 1);
    run_row(3, 100, 0, beats);
    chk("after_reset_beats", beats, 3);

    // Random rows with per-column latencies, including never-answering columns.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        lat_tab[c] = ($urandom_range(19) == 0) ? 0 : int'($urandom_range(40, 1));
        disp_tab[c] = DISP_BITS'($urandom);
      end
      run_row(int'($urandom_range(80)), int'($urandom_range(100, 30)), 0, beats);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
